// File: rtl/box_motion_ctrl_pkg.sv
// vga_ctrl_pkg: shared FSM states, colour palette, default VGA timing and the per-axis step/clamp helper.
package vga_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_t;

    // Entry n is colour index n, packed as {r,g,b}.
    localparam logic [3:0][11:0] PALETTE = {12'hFFF, 12'h00F, 12'h0F0, 12'hB00};

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int H_TOTAL_DEF  = 800;
    localparam int V_TOTAL_DEF  = 525;

    // Opposing or absent requests leave the position where it is.
    function automatic logic [10:0] step_axis(input logic [10:0] pos, input logic dec, input logic inc,
                                              input logic [10:0] step, input logic [10:0] lim);
        return (dec && !inc) ? ((pos > step) ? pos - step : 11'd0) :
               (inc && !dec) ? ((pos + step > lim) ? lim : pos + step) : pos;
    endfunction

endpackage

// File: rtl/box_motion_ctrl_if.sv
// box_motion_ctrl_if: scan counters into the controller, committed box geometry/colour and frame tick out.
interface box_motion_ctrl_if;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] box_x;
    logic [9:0] box_y;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       frame_tick;
    modport master(output x, y, input box_x, box_y, red, green, blue, frame_tick);
    modport slave(input x, y, output box_x, box_y, red, green, blue, frame_tick);
endinterface

// File: rtl/box_motion_ctrl_debounce.sv
// button_debounce: 2-FF synchroniser plus a stability counter; the output follows the input only after it holds steady.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic Drawingclk,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge Drawingclk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_cnt  <= '0;
            stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], raw};
            if (r_sync[1] == stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/box_motion_ctrl.sv
// box_motion_ctrl: debounced buttons move and recolour the VGA box once per frame,
// with position and colour committed only during vertical blanking.
module box_motion_ctrl
    import vga_ctrl_pkg::*;
#(
    parameter int H_ACTIVE        = H_ACTIVE_DEF,
    parameter int V_ACTIVE        = V_ACTIVE_DEF,
    parameter int BOX_W           = 200,
    parameter int BOX_H           = 200,
    parameter int STEP            = 4,
    parameter int INIT_X          = 300,
    parameter int INIT_Y          = 200,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              Drawingclk,
    input  logic              reset_n,
    input  logic              buttonup,
    input  logic              buttondown,
    input  logic              buttonleft,
    input  logic              buttonright,
    input  logic              buttonsel,
    box_motion_ctrl_if.slave  bus
);
    logic [4:0]  w_raw;
    logic [4:0]  w_btn;
    logic        w_blank;
    logic        w_sel_rise;
    logic [11:0] w_rgb;
    state_t      w_next;
    state_t      r_state;
    logic        r_blank_q;
    logic        r_tick;
    logic        r_sel_q;
    logic        r_pend;
    logic [1:0]  r_idx;
    logic [9:0]  r_box_x;
    logic [9:0]  r_box_y;
    logic [10:0] r_sh_x;
    logic [10:0] r_sh_y;

    assign w_raw = {buttonsel, buttonright, buttonleft, buttondown, buttonup};

    for (genvar g = 0; g < 5; g++) begin : g_db
        button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .Drawingclk(Drawingclk),
            .reset_n   (reset_n),
            .raw       (w_raw[g]),
            .stable    (w_btn[g])
        );
    end

    assign w_blank    = (bus.y == 10'(V_ACTIVE)) && (bus.x == 10'd0);
    assign w_sel_rise = w_btn[4] & ~r_sel_q;

    always_comb begin
        w_next = IDLE;
        w_next = (r_state == IDLE) ? (r_tick ? CALC : IDLE) :
                 (r_state == CALC) ? COMMIT : IDLE;
    end

    always_ff @(posedge Drawingclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_blank_q <= 1'b0;
            r_tick    <= 1'b0;
            r_sel_q   <= 1'b0;
            r_pend    <= 1'b0;
            r_idx     <= 2'd0;
            r_box_x   <= 10'(INIT_X);
            r_box_y   <= 10'(INIT_Y);
            r_sh_x    <= 11'(INIT_X);
            r_sh_y    <= 11'(INIT_Y);
        end else begin
            r_state   <= w_next;
            r_blank_q <= w_blank;
            r_tick    <= w_blank & ~r_blank_q;
            r_sel_q   <= w_btn[4];
            if (r_state == CALC) begin
                r_sh_x <= step_axis({1'b0, r_box_x}, w_btn[2], w_btn[3], 11'(STEP), 11'(H_ACTIVE - BOX_W));
                r_sh_y <= step_axis({1'b0, r_box_y}, w_btn[0], w_btn[1], 11'(STEP), 11'(V_ACTIVE - BOX_H));
            end
            // A select edge landing in the commit cycle itself carries over to the next frame.
            if (r_state == COMMIT) begin
                r_box_x <= r_sh_x[9:0];
                r_box_y <= r_sh_y[9:0];
                r_idx   <= r_idx + {1'b0, r_pend};
                r_pend  <= w_sel_rise;
            end else begin
                r_pend  <= r_pend | w_sel_rise;
            end
        end
    end

    assign w_rgb          = PALETTE[r_idx];
    assign bus.box_x      = r_box_x;
    assign bus.box_y      = r_box_y;
    assign bus.red        = w_rgb[11:8];
    assign bus.green      = w_rgb[7:4];
    assign bus.blue       = w_rgb[3:0];
    assign bus.frame_tick = r_tick;

endmodule

// File: tb/tb_box_motion_ctrl.sv
// tb_box_motion_ctrl: table-driven frames with a scoreboard of committed outputs, plus
// hand sequences for glitches, select presses, retick, mid-update reset and edge clamping.
module tb_box_motion_ctrl;

    typedef struct {
        int         dut;
        logic [9:0] x;
        logic [9:0] y;
        logic [11:0] rgb;
    } exp_t;

    typedef struct {
        logic [4:0]  btn;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sx = 10'd1;
    logic [9:0] sy = 10'd481;
    logic [4:0] btn1 = '0;
    logic [4:0] btn2 = '0;
    int         tests = 0;
    int         fails = 0;
    int         tick_total = 0;
    exp_t       sb[$];
    vec_t       vt[12];

    always #5 clk = ~clk;

    box_motion_ctrl_if bus1();
    box_motion_ctrl_if bus2();
    assign bus1.x = sx;
    assign bus1.y = sy;
    assign bus2.x = sx;
    assign bus2.y = sy;

    // btn bits: [0] up, [1] down, [2] left, [3] right, [4] sel
    box_motion_ctrl #(.DEBOUNCE_CYCLES(4)) dut1 (
        .Drawingclk(clk), .reset_n(rst_n),
        .buttonup(btn1[0]), .buttondown(btn1[1]), .buttonleft(btn1[2]),
        .buttonright(btn1[3]), .buttonsel(btn1[4]), .bus(bus1)
    );

    box_motion_ctrl #(.DEBOUNCE_CYCLES(4), .INIT_X(2), .INIT_Y(278)) dut2 (
        .Drawingclk(clk), .reset_n(rst_n),
        .buttonup(btn2[0]), .buttondown(btn2[1]), .buttonleft(btn2[2]),
        .buttonright(btn2[3]), .buttonsel(btn2[4]), .bus(bus2)
    );

    always @(posedge clk) if (bus1.frame_tick === 1'b1) tick_total++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic frame(input int hold);
        int t0;
        t0 = tick_total;
        @(negedge clk);
        sy = 10'd480;
        sx = 10'd0;
        repeat (hold) @(negedge clk);
        sx = 10'd1;
        @(negedge clk);
        sy = 10'd481;
        repeat (8) @(negedge clk);
        check("tick_once_per_frame", 32'(tick_total - t0), 32'd1);
    endtask

    task automatic sb_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (e.dut == 1) begin
                check({name, "_x"}, 32'(bus1.box_x), 32'(e.x));
                check({name, "_y"}, 32'(bus1.box_y), 32'(e.y));
                check({name, "_rgb"}, 32'({bus1.red, bus1.green, bus1.blue}), 32'(e.rgb));
            end else begin
                check({name, "_x"}, 32'(bus2.box_x), 32'(e.x));
                check({name, "_y"}, 32'(bus2.box_y), 32'(e.y));
                check({name, "_rgb"}, 32'({bus2.red, bus2.green, bus2.blue}), 32'(e.rgb));
            end
        end
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    initial begin
        vt[0]  = '{5'b00000, 10'd300, 10'd200, 12'hB00};
        vt[1]  = '{5'b00000, 10'd300, 10'd200, 12'hB00};
        vt[2]  = '{5'b00000, 10'd300, 10'd200, 12'hB00};
        vt[3]  = '{5'b01000, 10'd304, 10'd200, 12'hB00};
        vt[4]  = '{5'b01000, 10'd308, 10'd200, 12'hB00};
        vt[5]  = '{5'b01101, 10'd308, 10'd196, 12'hB00};
        vt[6]  = '{5'b01101, 10'd308, 10'd192, 12'hB00};
        vt[7]  = '{5'b10000, 10'd308, 10'd192, 12'h0F0};
        vt[8]  = '{5'b10000, 10'd308, 10'd192, 12'h00F};
        vt[9]  = '{5'b10100, 10'd304, 10'd192, 12'hFFF};
        vt[10] = '{5'b10010, 10'd304, 10'd196, 12'hB00};
        vt[11] = '{5'b00110, 10'd300, 10'd200, 12'hB00};

        repeat (3) @(negedge clk);
        check("rst_x", 32'(bus1.box_x), 32'd300);
        check("rst_y", 32'(bus1.box_y), 32'd200);
        check("rst_rgb", 32'({bus1.red, bus1.green, bus1.blue}), 32'hB00);
        check("rst_tick", 32'(bus1.frame_tick), 32'd0);
        check("rst2_x", 32'(bus2.box_x), 32'd2);
        rst_n = 1'b1;
        settle();

        for (int i = 0; i < 12; i++) begin
            btn1 = vt[i].btn;
            settle();
            sb.push_back('{1, vt[i].x, vt[i].y, vt[i].rgb});
            frame(1);
            sb_check($sformatf("vec%0d", i));
            btn1 = '0;
            settle();
        end

        // Two-cycle glitch on right never qualifies.
        @(negedge clk) btn1 = 5'b01000;
        @(negedge clk);
        @(negedge clk) btn1 = '0;
        settle();
        sb.push_back('{1, 10'd300, 10'd200, 12'hB00});
        frame(1);
        sb_check("glitch");

        // Two select presses in one frame count once; x held at 0 for 5 clocks still ticks once.
        btn1 = 5'b10000; settle();
        btn1 = '0;       settle();
        btn1 = 5'b10000; settle();
        btn1 = '0;       settle();
        sb.push_back('{1, 10'd300, 10'd200, 12'h0F0});
        frame(5);
        sb_check("double_sel");

        // Second blanking start while in COMMIT is ignored; outputs hold through CALC/COMMIT.
        btn1 = 5'b01000;
        settle();
        @(negedge clk);
        sy = 10'd480;
        sx = 10'd0;
        @(negedge clk);
        check("tick_pulse", 32'(bus1.frame_tick), 32'd1);
        check("hold_idle_x", 32'(bus1.box_x), 32'd300);
        sx = 10'd1;
        @(negedge clk);
        check("hold_calc_x", 32'(bus1.box_x), 32'd300);
        sx = 10'd0;
        @(negedge clk);
        check("retick_in_commit", 32'(bus1.frame_tick), 32'd1);
        check("hold_commit_x", 32'(bus1.box_x), 32'd300);
        sx = 10'd1;
        @(negedge clk);
        check("commit_x", 32'(bus1.box_x), 32'd304);
        @(negedge clk);
        sy = 10'd481;
        repeat (10) @(negedge clk);
        check("retick_ignored_x", 32'(bus1.box_x), 32'd304);

        // Reset while in CALC with right held: immediate init values, no commit until next frame.
        @(negedge clk);
        sy = 10'd480;
        sx = 10'd0;
        @(negedge clk);
        sx = 10'd1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_x", 32'(bus1.box_x), 32'd300);
        check("midrst_y", 32'(bus1.box_y), 32'd200);
        check("midrst_rgb", 32'({bus1.red, bus1.green, bus1.blue}), 32'hB00);
        check("midrst_tick", 32'(bus1.frame_tick), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sy = 10'd481;
        repeat (20) @(negedge clk);
        check("no_commit_after_rst", 32'(bus1.box_x), 32'd300);
        sb.push_back('{1, 10'd304, 10'd200, 12'hB00});
        frame(1);
        sb_check("after_rst");
        btn1 = '0;

        // Clamp at the left and bottom edges on the second instance.
        check("dut2_init_y", 32'(bus2.box_y), 32'd278);
        btn2 = 5'b00110;
        settle();
        sb.push_back('{2, 10'd0, 10'd280, 12'hB00});
        frame(1);
        sb_check("clamp1");
        sb.push_back('{2, 10'd0, 10'd280, 12'hB00});
        frame(1);
        sb_check("clamp2");
        btn2 = '0;

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
